// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for the 6-symbol gray-level alphabet, MSB of each codeword first.
// Optional macro HUFF_DEC_CNT_EN adds per-symbol decoded counts on DCNT1..DCNT6.
module huffman_decoder #(
  parameter int NSYM = 6,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          code_valid,
  input  logic [CW-1:0] HC1,
  input  logic [CW-1:0] HC2,
  input  logic [CW-1:0] HC3,
  input  logic [CW-1:0] HC4,
  input  logic [CW-1:0] HC5,
  input  logic [CW-1:0] HC6,
  input  logic [CW-1:0] M1,
  input  logic [CW-1:0] M2,
  input  logic [CW-1:0] M3,
  input  logic [CW-1:0] M4,
  input  logic [CW-1:0] M5,
  input  logic [CW-1:0] M6,
  input  logic          bit_valid,
  input  logic          bit_in,
  input  logic          flush,
  output logic          table_ready,
  output logic          sym_valid,
  output logic [2:0]    sym,
  output logic          err
`ifdef HUFF_DEC_CNT_EN
  ,
  output logic [7:0]    DCNT1,
  output logic [7:0]    DCNT2,
  output logic [7:0]    DCNT3,
  output logic [7:0]    DCNT4,
  output logic [7:0]    DCNT5,
  output logic [7:0]    DCNT6
`endif
);

  localparam int LW = $clog2(CW + 1);

  typedef enum logic {NO_TABLE, READY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] hc_q [NSYM];
  logic [CW-1:0] m_q  [NSYM];
  logic [CW-1:0] hc_in [NSYM];
  logic [CW-1:0] m_in  [NSYM];
  logic [CW-1:0] acc_q, acc_d, acc_next, full_mask;
  logic [LW-1:0] len_q, len_d, len_next, max_len_q, max_len_in;
  logic          sym_valid_d, err_d, hit;
  logic [2:0]    sym_d, hit_sym;

  assign hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
  assign m_in  = '{M1, M2, M3, M4, M5, M6};

  function automatic logic [LW-1:0] ones(input logic [CW-1:0] v);
    logic [LW-1:0] c;
    c = '0;
    for (int i = 0; i < CW; i++) c = c + LW'(v[i]);
    return c;
  endfunction

  // Masks are contiguous from bit 0, so the longest code is the largest popcount.
  always_comb begin
    max_len_in = '0;
    for (int n = 0; n < NSYM; n++)
      if (ones(m_in[n]) > max_len_in) max_len_in = ones(m_in[n]);
  end

  assign acc_next  = {acc_q[CW-2:0], bit_in};
  assign len_next  = len_q + LW'(1);
  assign full_mask = ~({CW{1'b1}} << len_next);

  // Scan from the top down so the lowest-numbered matching symbol wins.
  always_comb begin
    hit     = 1'b0;
    hit_sym = 3'd0;
    for (int n = NSYM - 1; n >= 0; n--) begin
      if (m_q[n] != '0 && m_q[n] == full_mask && (acc_next & m_q[n]) == hc_q[n]) begin
        hit     = 1'b1;
        hit_sym = 3'(n + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= NO_TABLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    len_d       = len_q;
    sym_d       = sym_q_hold();
    sym_valid_d = 1'b0;
    err_d       = 1'b0;
    if (code_valid) begin
      state_d = READY;
      acc_d   = '0;
      len_d   = '0;
    end else if (state_q == READY) begin
      if (flush) begin
        err_d = (len_q != '0);
        acc_d = '0;
        len_d = '0;
      end else if (bit_valid) begin
        if (hit) begin
          sym_valid_d = 1'b1;
          sym_d       = hit_sym;
          acc_d       = '0;
          len_d       = '0;
        end else if (len_next >= max_len_q) begin
          // Covers max_len == 0 too: every bit is then an error.
          err_d = 1'b1;
          acc_d = '0;
          len_d = '0;
        end else begin
          acc_d = acc_next;
          len_d = len_next;
        end
      end
    end
  end

  function automatic logic [2:0] sym_q_hold();
    return sym;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      len_q     <= '0;
      max_len_q <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
      sym       <= 3'd0;
      for (int n = 0; n < NSYM; n++) begin
        hc_q[n] <= '0;
        m_q[n]  <= '0;
      end
    end else begin
      acc_q     <= acc_d;
      len_q     <= len_d;
      sym_valid <= sym_valid_d;
      err       <= err_d;
      sym       <= sym_d;
      if (code_valid) begin
        max_len_q <= max_len_in;
        for (int n = 0; n < NSYM; n++) begin
          hc_q[n] <= hc_in[n];
          m_q[n]  <= m_in[n];
        end
      end
    end
  end

  assign table_ready = (state_q == READY);

`ifdef HUFF_DEC_CNT_EN
  logic [7:0] dcnt_q [NSYM];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NSYM; n++) dcnt_q[n] <= 8'd0;
    end else if (code_valid) begin
      for (int n = 0; n < NSYM; n++) dcnt_q[n] <= 8'd0;
    end else begin
      for (int n = 0; n < NSYM; n++)
        if (sym_valid_d && sym_d == 3'(n + 1)) dcnt_q[n] <= dcnt_q[n] + 8'd1;
    end
  end

  assign DCNT1 = dcnt_q[0];
  assign DCNT2 = dcnt_q[1];
  assign DCNT3 = dcnt_q[2];
  assign DCNT4 = dcnt_q[3];
  assign DCNT5 = dcnt_q[4];
  assign DCNT6 = dcnt_q[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed table/stream cases plus randomized
// streams compared every cycle against an integer-level decoding model.
module tb_huffman_decoder;

  logic       clk = 1'b0;
  logic       reset, code_valid, bit_valid, bit_in, flush;
  logic [7:0] tb_hc [1:6];
  logic [7:0] tb_m  [1:6];
  logic       table_ready, sym_valid, err;
  logic [2:0] sym;
`ifdef HUFF_DEC_CNT_EN
  logic [7:0] dcnt [1:6];
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state: codes as integers, partial codeword as value + length.
  int mdl_ready, macc, malen, mmax, exp_sv, exp_err, exp_sym;
  int mhc [1:6];
  int mlen [1:6];
  int mcnt [1:6];
  bit bitq [$];

  always #5 clk = ~clk;

  huffman_decoder dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(tb_hc[1]), .HC2(tb_hc[2]), .HC3(tb_hc[3]),
    .HC4(tb_hc[4]), .HC5(tb_hc[5]), .HC6(tb_hc[6]),
    .M1(tb_m[1]), .M2(tb_m[2]), .M3(tb_m[3]),
    .M4(tb_m[4]), .M5(tb_m[5]), .M6(tb_m[6]),
    .bit_valid(bit_valid), .bit_in(bit_in), .flush(flush),
    .table_ready(table_ready), .sym_valid(sym_valid), .sym(sym), .err(err)
`ifdef HUFF_DEC_CNT_EN
    , .DCNT1(dcnt[1]), .DCNT2(dcnt[2]), .DCNT3(dcnt[3]),
    .DCNT4(dcnt[4]), .DCNT5(dcnt[5]), .DCNT6(dcnt[6])
`endif
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mdl_ready = 0; macc = 0; malen = 0; mmax = 0;
    exp_sv = 0; exp_err = 0; exp_sym = 0;
    for (int n = 1; n <= 6; n++) begin
      mhc[n] = 0; mlen[n] = 0; mcnt[n] = 0;
    end
  endtask

  task automatic modelStep(input logic cv, input logic bv, input logic b, input logic fl);
    int hit;
    hit = 0;
    exp_sv = 0;
    exp_err = 0;
    if (cv) begin
      mdl_ready = 1; mmax = 0; macc = 0; malen = 0;
      for (int n = 1; n <= 6; n++) begin
        mhc[n]  = int'(tb_hc[n]);
        mlen[n] = $countones(tb_m[n]);
        if (mlen[n] > mmax) mmax = mlen[n];
        mcnt[n] = 0;
      end
    end else if (mdl_ready != 0) begin
      if (fl) begin
        if (malen > 0) exp_err = 1;
        macc = 0; malen = 0;
      end else if (bv) begin
        macc = macc * 2 + int'(b);
        malen++;
        for (int n = 1; n <= 6; n++)
          if (hit == 0 && mlen[n] != 0 && mlen[n] == malen && macc == mhc[n]) hit = n;
        if (hit != 0) begin
          exp_sv = 1; exp_sym = hit;
          mcnt[hit] = (mcnt[hit] + 1) % 256;
          macc = 0; malen = 0;
        end else if (malen >= mmax) begin
          exp_err = 1;
          macc = 0; malen = 0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    check("table_ready", int'(table_ready), mdl_ready);
    check("sym_valid", int'(sym_valid), exp_sv);
    check("err", int'(err), exp_err);
    check("sym", int'(sym), exp_sym);
`ifdef HUFF_DEC_CNT_EN
    for (int n = 1; n <= 6; n++) check($sformatf("dcnt%0d", n), int'(dcnt[n]), mcnt[n]);
`endif
  endtask

  // Called at a falling edge: drive, advance the model, check just after the rising edge.
  task automatic applyStimulus(input logic cv, input logic bv, input logic b, input logic fl);
    code_valid = cv; bit_valid = bv; bit_in = b; flush = fl;
    modelStep(cv, bv, b, fl);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b1, bits[i], 1'b0);
  endtask

  task automatic setTableA();
    tb_hc = '{8'd0, 8'd2, 8'd6, 8'd14, 8'd30, 8'd31};
    tb_m  = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd31};
  endtask

  task automatic randTable();
    int len;
    for (int n = 1; n <= 6; n++) begin
      len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 8));
      tb_m[n]  = 8'((1 << len) - 1);
      tb_hc[n] = 8'($urandom) & tb_m[n];
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelReset();
    #1;
    check("reset table_ready", int'(table_ready), 0);
    check("reset sym_valid", int'(sym_valid), 0);
    check("reset sym", int'(sym), 0);
    check("reset err", int'(err), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int r, n;
    code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tb_hc[i] = 8'd0; tb_m[i] = 8'd0;
    end
    doReset();

    // Bits before any table are dropped
    feed(8'b000, 3);
    check("no table ready", int'(table_ready), 0);
    check("no table sym_valid", int'(sym_valid), 0);

    // Load with a simultaneous bit: load wins
    setTableA();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check("load ready", int'(table_ready), 1);

    // 0 | 10 | 11111 -> 1, 2, 6
    feed(8'b0, 1);
    check("A sym1 valid", int'(sym_valid), 1);
    check("A sym1", int'(sym), 1);
    feed(8'b10, 2);
    check("A sym2", int'(sym), 2);
    feed(8'b11111, 5);
    check("A sym6 valid", int'(sym_valid), 1);
    check("A sym6", int'(sym), 6);
    check("A sym6 err", int'(err), 0);

    // Back-to-back 1110 | 11110 -> 4, 5
    feed(8'b1110, 4);
    check("A sym4", int'(sym), 4);
    feed(8'b11110, 5);
    check("A sym5 valid", int'(sym_valid), 1);
    check("A sym5", int'(sym), 5);

    // Table B: symbol 6 unused, 11111 is illegal
    tb_m[6] = 8'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feed(8'b11111, 5);
    check("B err", int'(err), 1);
    check("B no sym_valid", int'(sym_valid), 0);
    check("B sym held", int'(sym), 5);
    feed(8'b0, 1);
    check("B sym1", int'(sym), 1);

    // Flush of a partial codeword, then flush when idle
    setTableA();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feed(8'b11, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    check("flush err", int'(err), 1);
    feed(8'b0, 1);
    check("after flush sym1", int'(sym), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check("idle flush no err", int'(err), 0);

`ifdef HUFF_DEC_CNT_EN
    feed(8'b0, 1); feed(8'b0, 1); feed(8'b10, 2); feed(8'b11111, 5);
    check("cnt reload dcnt1", int'(dcnt[1]), (mcnt[1]));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feed(8'b0, 1); feed(8'b0, 1); feed(8'b10, 2); feed(8'b11111, 5);
    check("dcnt1 lit", int'(dcnt[1]), 2);
    check("dcnt2 lit", int'(dcnt[2]), 1);
    check("dcnt3 lit", int'(dcnt[3]), 0);
    check("dcnt6 lit", int'(dcnt[6]), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check("dcnt1 cleared", int'(dcnt[1]), 0);
    check("dcnt6 cleared", int'(dcnt[6]), 0);
`endif

    // Randomized streams, mostly legal codewords, with flushes and reloads
    randTable();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (bitq.size() == 0) begin
        n = int'($urandom_range(1, 6));
        if ($urandom_range(0, 4) != 0 && mlen[n] > 0) begin
          for (int i = mlen[n] - 1; i >= 0; i--) bitq.push_back(bit'((mhc[n] >> i) & 1));
        end else begin
          bitq.push_back(bit'($urandom_range(0, 1)));
        end
      end
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        randTable();
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 6) begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), bitq.pop_front(), 1'b1);
      end else if (r < 30) begin
        applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        applyStimulus(1'b0, 1'b1, bitq.pop_front(), 1'b0);
      end
    end

    // Reset in the middle of a codeword needs a reload
    setTableA();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    feed(8'b11, 2);
    doReset();
    feed(8'b0, 1);
    check("post reset sym_valid", int'(sym_valid), 0);
    check("post reset ready", int'(table_ready), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
